// File: rtl/axi3m_sched.sv
// axi3m_sched: shares one AXI3 master port among N_REQ single-word requesters and runs one
// single-beat transaction at a time. Define AXI3M_SCHED_RR_EN for round-robin, otherwise fixed priority.
module axi3m_sched #(
  parameter int N_REQ    = 2,
  parameter int id_width = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  input  logic [4*N_REQ-1:0]    req_wstrb,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [id_width-1:0]   awid,
  output logic [31:0]           awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [id_width-1:0]   wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [id_width-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [id_width-1:0]   arid,
  output logic [31:0]           araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [id_width-1:0]   rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_RSP  = 3'd6
  } state_t;

  state_t              state_r;
  logic [id_width-1:0] gnt_r;
  logic [id_width-1:0] start_s;
  logic [id_width:0]   pick_s;
  logic [id_width-1:0] win_s;
  logic                hit_s;
  logic                sel_we_s;
  logic [31:0]         sel_addr_s;
  logic [31:0]         sel_wdata_s;
  logic [3:0]          sel_wstrb_s;

  // Scan from start, wrapping modulo N_REQ; returns {hit, index}. The downward loop lets the
  // requester closest to start win.
  function automatic logic [id_width:0] pick_fn(input logic [N_REQ-1:0]    v,
                                                input logic [id_width-1:0] start);
    logic [id_width:0] res;
    logic [N_REQ-1:0]  sh;
    int unsigned       idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (32'(start) + 32'(k)) % 32'(N_REQ);
      sh  = v >> idx;
      if (sh[0]) begin
        res = {1'b1, id_width'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef AXI3M_SCHED_RR_EN
  logic [id_width-1:0] ptr_r;

  // Round-robin pointer: moves past the requester just granted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_r <= '0;
    end else if (state_r == ST_IDLE && hit_s) begin
      ptr_r <= id_width'((32'(win_s) + 32'd1) % 32'(N_REQ));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign start_s = ptr_r;
`else
  assign start_s = '0;
`endif

  // Winner selection and payload mux of the winning requester.
  always_comb begin
    pick_s      = pick_fn(req_valid, start_s);
    hit_s       = pick_s[id_width];
    win_s       = pick_s[id_width-1:0];
    sel_we_s    = 1'(req_we >> win_s);
    sel_addr_s  = 32'(req_addr >> {win_s, 5'd0});
    sel_wdata_s = 32'(req_wdata >> {win_s, 5'd0});
    sel_wstrb_s = 4'(req_wstrb >> {win_s, 2'd0});
  end

  // Transaction FSM; every port output is a register of this block.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      awid      <= '0;
      awaddr    <= 32'd0;
      awvalid   <= 1'b0;
      wid       <= '0;
      wdata     <= 32'd0;
      wstrb     <= 4'd0;
      wlast     <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arid      <= '0;
      araddr    <= 32'd0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            gnt_r     <= win_s;
            req_ready <= N_REQ'(1'b1) << win_s;
            if (sel_we_s) begin
              awid    <= win_s;
              wid     <= win_s;
              awaddr  <= sel_addr_s;
              wdata   <= sel_wdata_s;
              wstrb   <= sel_wstrb_s;
              awvalid <= 1'b1;
              state_r <= ST_AW;
            end else begin
              arid    <= win_s;
              araddr  <= sel_addr_s;
              arvalid <= 1'b1;
              state_r <= ST_AR;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wlast   <= 1'b1;
            state_r <= ST_W;
          end else begin
            state_r <= ST_AW;
          end
        end
        ST_W: begin
          if (wvalid && wready) begin
            wvalid  <= 1'b0;
            wlast   <= 1'b0;
            bready  <= 1'b1;
            state_r <= ST_B;
          end else begin
            state_r <= ST_W;
          end
        end
        ST_B: begin
          if (bvalid && bready) begin
            bready    <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= (bresp != RESP_OKAY) || (bid != gnt_r);
            rsp_valid <= N_REQ'(1'b1) << gnt_r;
            state_r   <= ST_RSP;
          end else begin
            state_r <= ST_B;
          end
        end
        ST_AR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= ST_R;
          end else begin
            state_r <= ST_AR;
          end
        end
        ST_R: begin
          if (rvalid && rready) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_err   <= (rresp != RESP_OKAY) || (rid != gnt_r) || (rlast != 1'b1);
            rsp_valid <= N_REQ'(1'b1) << gnt_r;
            state_r   <= ST_RSP;
          end else begin
            state_r <= ST_R;
          end
        end
        // rsp_valid is high for exactly this state's cycle
        ST_RSP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi3m_sched.sv
// Table-driven bench for axi3m_sched with a small AXI3 slave model; grant-order expectations
// follow AXI3M_SCHED_RR_EN.
module tb_axi3m_sched;

  localparam int N  = 2;
  localparam int IW = 4;

  logic            aclk;
  logic            aresetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [32*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [4*N-1:0]  req_wstrb;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [IW-1:0]   awid, wid, bid, arid, rid;
  logic [31:0]     awaddr, wdata, araddr, rdata;
  logic [3:0]      wstrb;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [1:0]      bresp, rresp;

  axi3m_sched #(.N_REQ(N), .id_width(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    int          r;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [1:0]  resp;
    logic [3:0]  rsp_id;
    logic [31:0] rd;
    bit          last;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        tv[7];
  int          checks;
  int          errors;
  int          aw_delay;
  int          aw_cnt;
  bit          echo_id;
  logic [1:0]  s_resp;
  logic [3:0]  s_id;
  logic [31:0] s_rdata;
  bit          s_rlast;
  bit          got;
  logic [1:0]  ord[4];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Slave model: reacts at each falling edge so the DUT samples it on the next rising edge.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    bid = '0; bresp = 2'b00; rid = '0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
    aw_cnt = 0;
    forever begin
      @(negedge aclk);
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      if (!aresetn) begin
        aw_cnt = 0;
      end else begin
        if (awvalid) begin
          if (aw_cnt >= aw_delay) begin
            awready = 1'b1;
            aw_cnt  = 0;
          end else begin
            aw_cnt++;
          end
        end
        if (wvalid)  wready = 1'b1;
        if (arvalid) arready = 1'b1;
        if (bready) begin
          bvalid = 1'b1;
          bresp  = s_resp;
          bid    = echo_id ? awid : s_id;
        end
        if (rready) begin
          rvalid = 1'b1;
          rresp  = s_resp;
          rid    = echo_id ? arid : s_id;
          rdata  = s_rdata;
          rlast  = s_rlast;
        end
      end
    end
  end

  task automatic load_req(input int r, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
    req_we[r]          = we;
    req_addr[32*r+:32] = addr;
    req_wdata[32*r+:32] = wd;
    req_wstrb[4*r+:4]  = ws;
  endtask

  task automatic wait_rsp(input logic [1:0] oh, input logic [31:0] exp_rd, input bit exp_err);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge aclk);
      if (rsp_valid != 2'b00) begin
        done = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    @(negedge aclk);
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    logic [1:0] oh;
    bit         saw_w;
    bit         done;
    oh = 2'b01 << v.r;
    s_resp = v.resp; s_id = v.rsp_id; s_rdata = v.rd; s_rlast = v.last;
    @(negedge aclk);
    load_req(v.r, v.we, v.addr, v.wd, v.ws);
    req_valid[v.r] = 1'b1;
    @(negedge aclk);
    chk("req_ready", 32'(req_ready), 32'(oh));
    req_valid[v.r] = 1'b0;
    if (v.we) begin
      chk("awvalid", 32'(awvalid), 32'd1);
      chk("awaddr", awaddr, v.addr);
      chk("awid", 32'(awid), 32'(v.r));
      chk("arvalid_idle", 32'(arvalid), 32'd0);
    end else begin
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("araddr", araddr, v.addr);
      chk("arid", 32'(arid), 32'(v.r));
      chk("awvalid_idle", 32'(awvalid), 32'd0);
    end
    saw_w = 1'b0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge aclk);
      if (wvalid && !saw_w) begin
        saw_w = 1'b1;
        chk("wdata", wdata, v.wd);
        chk("wstrb", 32'(wstrb), 32'(v.ws));
        chk("wid", 32'(wid), 32'(v.r));
        chk("wlast", 32'(wlast), 32'd1);
        chk("aw_w_overlap", 32'(awvalid), 32'd0);
      end
      if (rsp_valid != 2'b00) begin
        done = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_rdata", rsp_rdata, v.exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    chk("w_phase_seen", 32'(saw_w), 32'(v.we));
    @(negedge aclk);
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; aw_delay = 0; echo_id = 1'b0;
    s_resp = 2'b00; s_id = 4'd0; s_rdata = 32'd0; s_rlast = 1'b1;
    aresetn = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

    //        r  we  addr          wdata         ws     resp   id     rdata         last  exp_rd        err
    tv[0] = '{0, 1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 2'b00, 4'd0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
    tv[1] = '{1, 0, 32'h0000_0020, 32'h0000_0000, 4'h0, 2'b00, 4'd1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    tv[2] = '{1, 1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3, 2'b10, 4'd1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    tv[3] = '{0, 0, 32'h0000_0040, 32'h0000_0000, 4'h0, 2'b00, 4'd3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1};
    tv[4] = '{0, 0, 32'h0000_0044, 32'h0000_0000, 4'h0, 2'b00, 4'd0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b1};
    tv[5] = '{0, 1, 32'h0000_0048, 32'h5555_AAAA, 4'h3, 2'b00, 4'd1, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    tv[6] = '{1, 0, 32'h0000_004C, 32'h0000_0000, 4'h0, 2'b11, 4'd1, 32'h7777_8888, 1'b1, 32'h7777_8888, 1'b1};

`ifdef AXI3M_SCHED_RR_EN
    ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01; ord[3] = 2'b10;
`else
    ord[0] = 2'b01; ord[1] = 2'b01; ord[2] = 2'b01; ord[3] = 2'b01;
`endif

    repeat (3) @(negedge aclk);
    chk("rst_ctrl", 32'({awvalid, wvalid, wlast, bready, arvalid, rready, rsp_err}), 32'd0);
    chk("rst_hs", 32'({req_ready, rsp_valid}), 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ids", 32'({awid, wid, arid, wstrb}), 32'd0);
    aresetn = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(tv[i]);

    // Contention: both requesters hold reads for four grants.
    echo_id = 1'b1; s_resp = 2'b00; s_rlast = 1'b1; s_rdata = 32'h0000_00C0;
    @(negedge aclk);
    load_req(0, 1'b0, 32'h0000_0100, 32'd0, 4'd0);
    load_req(1, 1'b0, 32'h0000_0200, 32'd0, 4'd0);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge aclk);
        if (req_ready != 2'b00) got = 1'b1;
      end
      if (n == 3) req_valid = 2'b00;
      chk("cont_grant", 32'(req_ready), 32'(ord[n]));
    end
    wait_rsp(ord[3], 32'h0000_00C0, 1'b0);
    echo_id = 1'b0;

    // Backpressure: awready held low for five cycles.
    aw_delay = 5; s_resp = 2'b00; s_id = 4'd0;
    @(negedge aclk);
    load_req(0, 1'b1, 32'h0000_0300, 32'h1111_2222, 4'hF);
    req_valid[0] = 1'b1;
    @(negedge aclk);
    chk("bp_req_ready", 32'(req_ready), 32'd1);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("bp_awvalid", 32'(awvalid), 32'd1);
      chk("bp_awaddr", awaddr, 32'h0000_0300);
      chk("bp_wvalid", 32'(wvalid), 32'd0);
    end
    wait_rsp(2'b01, 32'd0, 1'b0);
    aw_delay = 0;

    // Reset while in the W phase.
    @(negedge aclk);
    load_req(0, 1'b1, 32'h0000_0400, 32'h3333_4444, 4'hF);
    req_valid[0] = 1'b1;
    @(negedge aclk);
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge aclk);
      if (wvalid) got = 1'b1;
    end
    chk("rstw_reached_w", 32'(got), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("rstw_wvalid", 32'(wvalid), 32'd0);
    chk("rstw_wlast", 32'(wlast), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("rstw_quiet", 32'({rsp_valid, awvalid, arvalid, wvalid}), 32'd0);
    end
    run_txn('{0, 0, 32'h0000_0500, 32'h0000_0000, 4'h0, 2'b00, 4'd0, 32'h9ABC_DEF0, 1'b1,
              32'h9ABC_DEF0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi3m_sched.md
Name: axi3m_sched

Overview:
- Synthesizable scheduler that shares one AXI3 master port among N_REQ simple single-word requesters.
- Arbitrates pending requests and runs one 32-bit single-beat transaction at a time. The write sequence is AW, then W, then B; the read sequence is AR, then R.
- Returns read data and status to the granted requester. It sits between register-access clients (CPU stub, DMA config, test sequencer) and an AXI3 slave or interconnect.

Parameters:
- N_REQ, 2, number of requesters; legal range 1..2**id_width.
- id_width, 4, AXI ID width.
- AXI constants are tied at integration and are not ports: awlen/arlen=0, awsize/arsize=BYTE4, awburst/arburst=INCR, lock/cache/prot=0.

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester request pending; held until req_ready
- req_ready  output  N_REQ  one-hot accept pulse
- req_we  input  N_REQ  1=write, 0=read
- req_addr  input  32*N_REQ  packed addresses; requester i at [32*i+:32]
- req_wdata  input  32*N_REQ  packed write data
- req_wstrb  input  4*N_REQ  packed byte strobes
- rsp_valid  output  N_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  output  32  read data, valid with rsp_valid (0 for writes)
- rsp_err  output  1  error flag, valid with rsp_valid
- awid  output  id_width  granted requester index, zero-extended
- awaddr  output  32  write address
- awvalid  output  1  AW valid
- awready  input  1  AW ready
- wid  output  id_width  equals awid
- wdata  output  32  write data
- wstrb  output  4  write strobes
- wlast  output  1  constant 1 while wvalid
- wvalid  output  1  W valid
- wready  input  1  W ready
- bid  input  id_width  write response ID
- bresp  input  2  write response
- bvalid  input  1  B valid
- bready  output  1  B ready
- arid  output  id_width  granted requester index
- araddr  output  32  read address
- arvalid  output  1  AR valid
- arready  input  1  AR ready
- rid  input  id_width  read ID
- rdata  input  32  read data
- rresp  input  2  read response
- rlast  input  1  read last
- rvalid  input  1  R valid
- rready  output  1  R ready

Behaviour:
- Reset values: all outputs registered, with no intra-assignment delays. On aresetn low, immediately: every valid, ready, req_ready and rsp_valid output = 0; rsp_err=0; rsp_rdata=0; IDs, addresses, wdata=0; wstrb=0; wlast=0; round-robin pointer=0; state=IDLE.
- Reset mid-transaction abandons the transaction with no response pulse. Requesters must re-issue.
- States: IDLE, AW, W, B, AR, R, RSP.
- IDLE: if any req_valid, select a winner and pulse req_ready[g]=1 for exactly one cycle. In the same edge, capture we/addr/wdata/wstrb and load the AXI payload with ID=g. Assert awvalid=1 and go to AW if we=1; else arvalid=1 and go to AR.
- Arbitration latency: req_valid high in cycle t gives awvalid/arvalid high at edge t+1.
- AW: hold the payload stable. On awvalid&&awready: awvalid=0, wvalid=1, wlast=1, go to W. AW and W are never concurrent.
- W: on wvalid&&wready: wvalid=0, wlast=0, bready=1, go to B.
- B: on bvalid&&bready: bready=0, rsp_rdata=0, rsp_err=(bresp!=OKAY)||(bid!=g), go to RSP.
- AR: on arvalid&&arready: arvalid=0, rready=1, go to R.
- R: on rvalid&&rready: rready=0, rsp_rdata=rdata, rsp_err=(rresp!=OKAY)||(rid!=g)||(rlast!=1), go to RSP.
- RSP: rsp_valid[g]=1 for one cycle, then IDLE. A new grant earliest the cycle after RSP.
- Only one outstanding transaction. Ready signals in a given state are already high when the slave asserts valid early, so a slave response on the same edge completes immediately.
- Round-robin: search starts at ptr and wraps modulo N_REQ. After a grant to g, ptr=(g+1) mod N_REQ. With N_REQ=1, ptr stays 0.
- A requester dropping req_valid before req_ready is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro AXI3M_SCHED_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, where the lowest index wins and there is no pointer state. Requester 0 can starve others.

Test Plan:
- Single write: req0 we=1, addr=0x10, wdata=0xA5A5_0001, wstrb=0xF; slave awready/wready/bvalid each 1 cycle later with bresp=0, bid=0 -> awaddr=0x10, wdata=0xA5A5_0001, wid=0, rsp_valid[0] one pulse, rsp_err=0.
- Single read: req1 we=0, addr=0x20; slave rdata=0x1234_5678, rid=1, rlast=1 -> arid=1, rsp_valid[1] pulse, rsp_rdata=0x1234_5678, rsp_err=0.
- Contention (RR_EN defined): req0 and req1 held continuously for 4 transactions -> grant order 0,1,0,1. Without the macro -> 0,0,0,0.
- Error paths: bresp=SLVERR -> rsp_err=1. Read with rid=3 (expected 0) -> rsp_err=1. Read with rlast=0 -> rsp_err=1.
- Backpressure: awready held low 5 cycles -> awvalid/awaddr stable throughout, wvalid stays 0 until the AW handshake.
- aresetn asserted in the W state -> wvalid=0 immediately, no rsp_valid. After release, a fresh req0 read completes normally.
